// File: rtl/ysyx_24110015_axi_arbiter_if.sv
// AXI-lite bundle: AR/R/AW/W/B channels with handshakes.
// master drives requests, slave drives responses.
interface ysyx_24110015_axi_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;

  modport master (
    output arvalid, araddr, rready,
    output awvalid, awaddr, wvalid,
    output wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready,
    input  awvalid, awaddr, wvalid,
    input  wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_24110015_axi_arbiter.sv
// Two-master (m0 IFU, m1 LSU) to one-slave AXI-lite arbiter.
// Ports: clk, rst (async, active-low), m0/m1 slave side, s master side, grant.
module ysyx_24110015_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_24110015_axi_arbiter_if.slave    m0,
  ysyx_24110015_axi_arbiter_if.slave    m1,
  ysyx_24110015_axi_arbiter_if.master   s,
  output logic [1:0]                    grant
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   ar_done_q, aw_done_q, w_done_q;
  logic   pick;

  logic req0, req1;
  logic rd, wr;
  logic own0, own1;

  logic              sel_arvalid;
  logic [ADDR_W-1:0] sel_araddr;
  logic              sel_rready;
  logic              sel_awvalid;
  logic [ADDR_W-1:0] sel_awaddr;
  logic              sel_wvalid;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;
  logic              sel_bready;

  logic s_arvalid, s_awvalid, s_wvalid;

  assign req0 = m0.arvalid | m0.awvalid | m0.wvalid;
  assign req1 = m1.arvalid | m1.awvalid | m1.wvalid;

  assign rd   = (state_q == RD);
  assign wr   = (state_q == WR);
  assign own0 = ~owner_q;
  assign own1 = owner_q;

  assign sel_arvalid = owner_q ? m1.arvalid : m0.arvalid;
  assign sel_araddr  = owner_q ? m1.araddr  : m0.araddr;
  assign sel_rready  = owner_q ? m1.rready  : m0.rready;
  assign sel_awvalid = owner_q ? m1.awvalid : m0.awvalid;
  assign sel_awaddr  = owner_q ? m1.awaddr  : m0.awaddr;
  assign sel_wvalid  = owner_q ? m1.wvalid  : m0.wvalid;
  assign sel_wdata   = owner_q ? m1.wdata   : m0.wdata;
  assign sel_wstrb   = owner_q ? m1.wstrb   : m0.wstrb;
  assign sel_bready  = owner_q ? m1.bready  : m0.bready;

  // Each address/data beat is forwarded once per grant; a fresh
  // request from the owner waits for the next arbitration round.
  assign s_arvalid = rd & ~ar_done_q & sel_arvalid;
  assign s_awvalid = wr & ~aw_done_q & sel_awvalid;
  assign s_wvalid  = wr & ~w_done_q  & sel_wvalid;

  assign s.arvalid = s_arvalid;
  assign s.araddr  = sel_araddr;
  assign s.rready  = rd & sel_rready;
  assign s.awvalid = s_awvalid;
  assign s.awaddr  = sel_awaddr;
  assign s.wvalid  = s_wvalid;
  assign s.wdata   = sel_wdata;
  assign s.wstrb   = sel_wstrb;
  assign s.bready  = wr & sel_bready;

  assign m0.arready = rd & own0 & ~ar_done_q & s.arready;
  assign m0.rvalid  = rd & own0 & s.rvalid;
  assign m0.rdata   = s.rdata;
  assign m0.rresp   = s.rresp;
  assign m0.awready = wr & own0 & ~aw_done_q & s.awready;
  assign m0.wready  = wr & own0 & ~w_done_q & s.wready;
  assign m0.bvalid  = wr & own0 & s.bvalid;
  assign m0.bresp   = s.bresp;

  assign m1.arready = rd & own1 & ~ar_done_q & s.arready;
  assign m1.rvalid  = rd & own1 & s.rvalid;
  assign m1.rdata   = s.rdata;
  assign m1.rresp   = s.rresp;
  assign m1.awready = wr & own1 & ~aw_done_q & s.awready;
  assign m1.wready  = wr & own1 & ~w_done_q & s.wready;
  assign m1.bvalid  = wr & own1 & s.bvalid;
  assign m1.bresp   = s.bresp;

  assign grant = (rd | wr) ? {own1, own0} : 2'b00;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    pick    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          // Tie goes to whoever did not finish last.
          pick    = (req0 & req1) ? ~last_q : req1;
          owner_d = pick;
          // Read wins when the winner raises ar and aw together.
          state_d = (pick ? m1.arvalid : m0.arvalid) ? RD : WR;
        end
      end
      RD: begin
        if (s.rvalid & sel_rready) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      WR: begin
        if (s.bvalid & sel_bready) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      ar_done_q <= ar_done_q | (s_arvalid & s.arready);
      aw_done_q <= aw_done_q | (s_awvalid & s.awready);
      w_done_q  <= w_done_q  | (s_wvalid  & s.wready);
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_axi_arbiter.sv
// Directed self-checking bench for the AXI-lite arbiter.
// Bench drives both masters and plays the slave by hand.
module tb_ysyx_24110015_axi_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] grant;
  int         n_cmp;
  int         n_err;

  ysyx_24110015_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0();
  ysyx_24110015_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1();
  ysyx_24110015_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s();

  ysyx_24110015_axi_arbiter #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .m0    (m0.slave),
    .m1    (m1.slave),
    .s     (s.master),
    .grant (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0]  exp_g [4];
  logic [31:0] exp_d;

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b0;
    m0.arvalid = 0; m0.araddr = '0; m0.rready = 0;
    m0.awvalid = 0; m0.awaddr = '0; m0.wvalid = 0;
    m0.wdata = '0; m0.wstrb = '0; m0.bready = 0;
    m1.arvalid = 0; m1.araddr = '0; m1.rready = 0;
    m1.awvalid = 0; m1.awaddr = '0; m1.wvalid = 0;
    m1.wdata = '0; m1.wstrb = '0; m1.bready = 0;
    s.arready = 0; s.rvalid = 0; s.rdata = '0; s.rresp = 0;
    s.awready = 0; s.wready = 0; s.bvalid = 0; s.bresp = 0;
    #1;
    chk("rst_grant", 64'(grant), 64'(2'b00));
    chk("rst_s_arvalid", 64'(s.arvalid), 64'd0);
    chk("rst_m0_arready", 64'(m0.arready), 64'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // single m0 read
    m0.arvalid = 1; m0.araddr = 32'h8000_0000;
    #1;
    chk("t1_idle_grant", 64'(grant), 64'(2'b00));
    chk("t1_idle_s_arvalid", 64'(s.arvalid), 64'd0);
    chk("t1_idle_m0_arready", 64'(m0.arready), 64'd0);
    tick();
    chk("t1_grant", 64'(grant), 64'(2'b01));
    chk("t1_s_arvalid", 64'(s.arvalid), 64'd1);
    chk("t1_s_araddr", 64'(s.araddr), 64'h8000_0000);
    s.arready = 1;
    #1;
    chk("t1_m0_arready", 64'(m0.arready), 64'd1);
    tick();
    m0.arvalid = 0; s.arready = 0;
    s.rvalid = 1; s.rdata = 32'h1234_5678; s.rresp = 0;
    m0.rready = 1;
    #1;
    chk("t1_m0_rvalid", 64'(m0.rvalid), 64'd1);
    chk("t1_m0_rdata", 64'(m0.rdata), 64'h1234_5678);
    chk("t1_m1_rvalid", 64'(m1.rvalid), 64'd0);
    tick();
    s.rvalid = 0; m0.rready = 0;
    #1;
    chk("t1_end_grant", 64'(grant), 64'(2'b00));
    chk("t1_end_m0_rvalid", 64'(m0.rvalid), 64'd0);

    // m0 read vs m1 write right after reset
    rst = 0;
    tick();
    rst = 1;
    m0.arvalid = 1; m0.araddr = 32'h8000_0010;
    m1.awvalid = 1; m1.awaddr = 32'h0000_2000;
    m1.wvalid = 1; m1.wdata = 32'hDEAD_BEEF; m1.wstrb = 4'hF;
    tick();
    chk("t2_grant_rd", 64'(grant), 64'(2'b01));
    chk("t2_s_awvalid", 64'(s.awvalid), 64'd0);
    s.arready = 1; s.awready = 1; s.wready = 1;
    #1;
    chk("t2_m1_awready", 64'(m1.awready), 64'd0);
    chk("t2_m1_wready", 64'(m1.wready), 64'd0);
    tick();
    m0.arvalid = 0; s.arready = 0; s.awready = 0; s.wready = 0;
    s.rvalid = 1; s.rdata = 32'h0BAD_F00D; m0.rready = 1;
    #1;
    chk("t2_m0_rvalid", 64'(m0.rvalid), 64'd1);
    tick();
    s.rvalid = 0; m0.rready = 0;
    #1;
    chk("t2_idle_grant", 64'(grant), 64'(2'b00));
    tick();
    chk("t2_grant_wr", 64'(grant), 64'(2'b10));
    chk("t2_s_awvalid_wr", 64'(s.awvalid), 64'd1);
    chk("t2_s_wvalid_wr", 64'(s.wvalid), 64'd1);
    chk("t2_s_wdata", 64'(s.wdata), 64'hDEAD_BEEF);
    s.awready = 1; s.wready = 1;
    #1;
    chk("t2_m1_awready_wr", 64'(m1.awready), 64'd1);
    chk("t2_m1_wready_wr", 64'(m1.wready), 64'd1);
    tick();
    m1.awvalid = 0; m1.wvalid = 0; s.awready = 0; s.wready = 0;
    s.bvalid = 1; s.bresp = 0; m1.bready = 1;
    #1;
    chk("t2_m1_bvalid", 64'(m1.bvalid), 64'd1);
    chk("t2_m0_bvalid", 64'(m0.bvalid), 64'd0);
    tick();
    chk("t2_m1_bvalid_once", 64'(m1.bvalid), 64'd0);
    s.bvalid = 0; m1.bready = 0;
    #1;
    chk("t2_end_grant", 64'(grant), 64'(2'b00));

    // four reads, both masters always asking
    m0.arvalid = 1; m0.araddr = 32'h8000_0100; m0.rready = 1;
    m1.arvalid = 1; m1.araddr = 32'h8000_0200; m1.rready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_gap_grant", 64'(grant), 64'(2'b00));
      tick();
      chk("t3_grant", 64'(grant), 64'(exp_g[i]));
      s.arready = 1;
      #1;
      chk("t3_s_arvalid", 64'(s.arvalid), 64'd1);
      tick();
      s.arready = 0;
      exp_d = 32'hA0 + 32'(i);
      s.rvalid = 1; s.rdata = exp_d;
      #1;
      chk("t3_s_arvalid_masked", 64'(s.arvalid), 64'd0);
      if (exp_g[i] == 2'b01) begin
        chk("t3_m0_rvalid", 64'(m0.rvalid), 64'd1);
        chk("t3_m1_rvalid", 64'(m1.rvalid), 64'd0);
        chk("t3_m0_rdata", 64'(m0.rdata), 64'(exp_d));
      end else begin
        chk("t3_m1_rvalid", 64'(m1.rvalid), 64'd1);
        chk("t3_m0_rvalid", 64'(m0.rvalid), 64'd0);
        chk("t3_m1_rdata", 64'(m1.rdata), 64'(exp_d));
      end
      tick();
      s.rvalid = 0;
    end
    m0.arvalid = 0; m1.arvalid = 0;
    m0.rready = 0; m1.rready = 0;
    tick();

    // m1 write, w late, slave awready late
    m1.awvalid = 1; m1.awaddr = 32'h0000_3000;
    #1;
    chk("t4_idle_s_awvalid", 64'(s.awvalid), 64'd0);
    tick();
    chk("t4_grant", 64'(grant), 64'(2'b10));
    chk("t4_s_awvalid", 64'(s.awvalid), 64'd1);
    chk("t4_s_wvalid", 64'(s.wvalid), 64'd0);
    tick();
    chk("t4_grant_hold", 64'(grant), 64'(2'b10));
    chk("t4_m1_awready_wait", 64'(m1.awready), 64'd0);
    tick();
    m1.wvalid = 1; m1.wdata = 32'h0000_CAFE; m1.wstrb = 4'h3;
    s.awready = 1; s.wready = 1;
    #1;
    chk("t4_s_wvalid_late", 64'(s.wvalid), 64'd1);
    chk("t4_s_wstrb", 64'(s.wstrb), 64'h3);
    chk("t4_m1_awready", 64'(m1.awready), 64'd1);
    chk("t4_m1_wready", 64'(m1.wready), 64'd1);
    tick();
    m1.awvalid = 0; m1.wvalid = 0; s.awready = 0; s.wready = 0;
    s.bvalid = 1; s.bresp = 2'b00; m1.bready = 0;
    #1;
    chk("t4_m1_bvalid", 64'(m1.bvalid), 64'd1);
    tick();
    chk("t4_grant_until_b", 64'(grant), 64'(2'b10));
    m1.bready = 1;
    #1;
    chk("t4_s_bready", 64'(s.bready), 64'd1);
    tick();
    s.bvalid = 0; m1.bready = 0;
    #1;
    chk("t4_end_grant", 64'(grant), 64'(2'b00));

    // reset in the middle of a read
    m0.arvalid = 1; m0.araddr = 32'h8000_0400;
    tick();
    chk("t5_grant", 64'(grant), 64'(2'b01));
    s.arready = 1;
    tick();
    m0.arvalid = 0; s.arready = 0;
    s.rvalid = 1; s.rdata = 32'h5555_AAAA; m0.rready = 1;
    rst = 0;
    #1;
    chk("t5_rst_m0_rvalid", 64'(m0.rvalid), 64'd0);
    chk("t5_rst_grant", 64'(grant), 64'(2'b00));
    chk("t5_rst_s_rready", 64'(s.rready), 64'd0);
    tick();
    rst = 1;
    tick();
    chk("t5_post_m0_rvalid", 64'(m0.rvalid), 64'd0);
    chk("t5_post_grant", 64'(grant), 64'(2'b00));
    s.rvalid = 0; m0.rready = 0;

    // m1 ar+aw together, SLVERR read then separate write
    m1.arvalid = 1; m1.araddr = 32'h0000_4000;
    m1.awvalid = 1; m1.awaddr = 32'h0000_4004;
    m1.wvalid = 1; m1.wdata = 32'h7777_0000; m1.wstrb = 4'hF;
    tick();
    chk("t6_grant_rd", 64'(grant), 64'(2'b10));
    chk("t6_s_arvalid", 64'(s.arvalid), 64'd1);
    chk("t6_s_awvalid", 64'(s.awvalid), 64'd0);
    s.arready = 1;
    tick();
    m1.arvalid = 0; s.arready = 0;
    s.rvalid = 1; s.rresp = 2'd2; s.rdata = 32'h0; m1.rready = 1;
    #1;
    chk("t6_m1_rvalid", 64'(m1.rvalid), 64'd1);
    chk("t6_m1_rresp", 64'(m1.rresp), 64'd2);
    tick();
    s.rvalid = 0; s.rresp = 0; m1.rready = 0;
    #1;
    chk("t6_idle_grant", 64'(grant), 64'(2'b00));
    tick();
    chk("t6_grant_wr", 64'(grant), 64'(2'b10));
    chk("t6_s_awvalid_wr", 64'(s.awvalid), 64'd1);
    chk("t6_s_awaddr", 64'(s.awaddr), 64'h0000_4004);
    s.awready = 1; s.wready = 1;
    tick();
    m1.awvalid = 0; m1.wvalid = 0; s.awready = 0; s.wready = 0;
    s.bvalid = 1; s.bresp = 2'd3; m1.bready = 1;
    #1;
    chk("t6_m1_bvalid", 64'(m1.bvalid), 64'd1);
    chk("t6_m1_bresp", 64'(m1.bresp), 64'd3);
    tick();
    s.bvalid = 0; s.bresp = 0; m1.bready = 0;
    #1;
    chk("t6_end_grant", 64'(grant), 64'(2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
